unary_frame_gen: RTL and testbench

UNARY_FRAME_GEN -- requirements
Module: unary_frame_gen

---
 rtl/unary_frame_gen.sv | 102 ++++++++++
 tb/tb_unary_frame_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/unary_frame_gen.sv
// unary_frame_gen: serialises a count as a fixed-length unary frame.
// Optional thermometer output enabled by UNARY_FRAME_THERM_OUT_EN.
module unary_frame_gen #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] in_count,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_bit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          ovf
`ifdef UNARY_FRAME_THERM_OUT_EN
  ,
  output logic [WIDTH-1:0] therm_out
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] idx;
  logic [CW-1:0] idx_nxt;
  logic [CW-1:0] sat;
  logic          big;

  assign big     = in_count > CW'(WIDTH);
  assign sat     = big ? CW'(WIDTH) : in_count;
  assign idx_nxt = idx + CW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      in_ready  <= 1'b1;
      ovf       <= 1'b0;
    end else begin
      ovf <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= SEND;
            cnt       <= sat;
            idx       <= '0;
            out_bit   <= sat != '0;
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
            ovf       <= big;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              idx       <= '0;
              out_bit   <= 1'b0;
              out_last  <= 1'b0;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              idx      <= idx_nxt;
              out_bit  <= idx_nxt < cnt;
              out_last <= idx_nxt == CW'(WIDTH - 1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UNARY_FRAME_THERM_OUT_EN
  logic [WIDTH-1:0] therm_nxt;

  always_comb begin
    therm_nxt = '0;
    for (int i = 0; i < WIDTH; i++)
      therm_nxt[i] = CW'(i) < sat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      therm_out <= '0;
    else if (state == IDLE && in_valid)
      therm_out <= therm_nxt;
  end
`endif

endmodule

// File: tb/tb_unary_frame_gen.sv
// tb_unary_frame_gen: vector table, corner sequences and random
// frames against a count-based reference model.
module tb_unary_frame_gen;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] in_count;
  logic          in_valid;
  logic          in_ready;
  logic          out_bit;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          ovf;
`ifdef UNARY_FRAME_THERM_OUT_EN
  logic [W-1:0]  therm_out;
`endif

  int errors = 0;
  int checks = 0;

  unary_frame_gen #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_count (in_count),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_bit  (out_bit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .ovf      (ovf)
`ifdef UNARY_FRAME_THERM_OUT_EN
    ,
    .therm_out(therm_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          count;
    int          mode;
    bit          hold;
    bit          exp_ovf;
    logic [W-1:0] exp_bits;
  } vec_t;

  // Reference: a frame is min(count,W) ones, lowest index first.
  function automatic logic [W-1:0] model_bits(input int c);
    int s;
    logic [W-1:0] b;
    s = (c > W) ? W : c;
    b = '0;
    for (int i = 0; i < s; i++) b[i] = 1'b1;
    return b;
  endfunction

  // Entered and left at a negedge with the DUT idle.
  task automatic run_frame(input int c, input int mode, input bit hold,
                           input bit exp_ovf, input logic [W-1:0] eb);
    int  n, cyc;
    bit  r, stalled, pb, pl, done;
    chk("idle_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_count = CW'(c);
    @(posedge clk);
    @(negedge clk);
    if (hold) in_count = CW'(2);
    else in_valid = 1'b0;
    chk("ovf_pulse", ovf, exp_ovf);
`ifdef UNARY_FRAME_THERM_OUT_EN
    chk("therm_out", therm_out, model_bits(c));
`endif
    n = 0; cyc = 0; stalled = 0; pb = 0; pl = 0; done = 0;
    while (!done && cyc < 100) begin
      unique case (mode)
        0: r = 1'b1;
        1: r = (cyc % 3) == 0;
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      chk("send_valid", out_valid, 1);
      chk("send_in_ready", in_ready, 0);
      if (cyc > 0) chk("ovf_low", ovf, 0);
      if (stalled) begin
        chk("stall_bit", out_bit, pb);
        chk("stall_last", out_last, pl);
      end
      if (r) begin
        chk("bit", out_bit, eb[n]);
        chk("last", out_last, n == W - 1);
        if (out_last === 1'b1) done = 1;
        n++;
      end
      stalled = !r; pb = out_bit; pl = out_last;
      cyc++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("frame_done", done, 1);
    chk("transfers", n, W);
    if (mode == 0) chk("frame_cycles", cyc, W);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("end_valid", out_valid, 0);
    chk("end_in_ready", in_ready, 1);
    chk("end_last", out_last, 0);
`ifdef UNARY_FRAME_THERM_OUT_EN
    chk("therm_hold", therm_out, model_bits(c));
`endif
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_bit"}, out_bit, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  vec_t vecs[$];

  initial begin
    int c;
    rst_n = 1'b0; in_count = '0; in_valid = 1'b0; out_ready = 1'b1;
    vecs.push_back('{3,  0, 0, 0, 8'b0000_0111});
    vecs.push_back('{0,  0, 0, 0, 8'b0000_0000});
    vecs.push_back('{8,  0, 0, 0, 8'b1111_1111});
    vecs.push_back('{13, 0, 0, 1, 8'b1111_1111});
    vecs.push_back('{5,  1, 0, 0, 8'b0001_1111});
    vecs.push_back('{1,  0, 1, 0, 8'b0000_0001});
    vecs.push_back('{7,  1, 1, 0, 8'b0111_1111});
    vecs.push_back('{9,  0, 0, 1, 8'b1111_1111});
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
`ifdef UNARY_FRAME_THERM_OUT_EN
    chk("reset_therm", therm_out, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // Back-to-back frames, including held in_valid during SEND.
    foreach (vecs[i])
      run_frame(vecs[i].count, vecs[i].mode, vecs[i].hold,
                vecs[i].exp_ovf, vecs[i].exp_bits);

    // Reset after the 4th bit aborts the frame.
    in_valid = 1'b1; in_count = CW'(6);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre_abort_valid", out_valid, 1);
    chk("pre_abort_last", out_last, 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle("abort");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("abort_rel");
    run_frame(2, 0, 0, 0, 8'b0000_0011);

    // Random frames against the model.
    for (int k = 0; k < 25; k++) begin
      c = $urandom_range(0, 15);
      run_frame(c, 2, 1'($urandom_range(0, 1)), c > W, model_bits(c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
